chess_clock_controller: RTL and testbench

//   Two-player chess clock sequencer. Owns both countdown timers and delivers them in packed m:ss

---
 rtl/chess_clock_controller.sv | 163 ++++++++++++++++
 tb/tb_chess_clock_controller.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/chess_clock_controller.sv
// chess_clock_controller: two-player chess clock with 1 s prescaler, BCD m:ss countdowns and flag detection.
// Inputs are rising-edge detected; every output comes straight from a register.
module chess_clock_controller #(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int START_MIN     = 5,
    parameter int START_TENS    = 0,
    parameter int START_UNITS   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       press_w,
    input  logic       press_b,
    input  logic       pause,
    input  logic       reload,
    output logic [9:0] countdownW,
    output logic [9:0] countdownB,
    output logic       turn_b,
    output logic       running,
    output logic       flagW,
    output logic       flagB
);
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [9:0] START = {3'(START_MIN), 3'(START_TENS), 4'(START_UNITS)};
    localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [2:0] {IDLE, RUN_W, RUN_B, PAUSED, FLAG} state_t;

    state_t        r_state, w_state_n;
    logic [PW-1:0] r_pre, w_pre_n, w_pre_inc;
    logic [9:0]    r_cdw, r_cdb, w_cdw_n, w_cdb_n, w_dec_w, w_dec_b;
    logic          r_turn, r_run, r_fw, r_fb;
    logic          w_turn_n, w_run_n, w_fw_n, w_fb_n, w_tick;
    logic          r_start_d, r_pw_d, r_pb_d, r_pause_d, r_reload_d;
    logic          w_e_start, w_e_pw, w_e_pb, w_e_pause, w_e_reload;

    // Borrow chain stops at 0:00 so the value can never wrap.
    function automatic logic [9:0] f_dec(input logic [9:0] v);
        return (v == 10'd0)      ? v :
               (v[3:0] != 4'd0)  ? {v[9:4], v[3:0] - 4'd1} :
               (v[6:4] != 3'd0)  ? {v[9:7], v[6:4] - 3'd1, 4'd9} :
                                   {v[9:7] - 3'd1, 3'd5, 4'd9};
    endfunction

    assign w_e_start  = start   & ~r_start_d;
    assign w_e_pw     = press_w & ~r_pw_d;
    assign w_e_pb     = press_b & ~r_pb_d;
    assign w_e_pause  = pause   & ~r_pause_d;
    assign w_e_reload = reload  & ~r_reload_d;
    assign w_tick     = (r_pre == TERM);
    assign w_pre_inc  = w_tick ? '0 : r_pre + 1'b1;
    assign w_dec_w    = f_dec(r_cdw);
    assign w_dec_b    = f_dec(r_cdb);

    always_comb begin
        w_state_n = r_state;
        w_pre_n   = r_pre;
        w_cdw_n   = r_cdw;
        w_cdb_n   = r_cdb;
        w_turn_n  = r_turn;
        w_fw_n    = r_fw;
        w_fb_n    = r_fb;
        case (r_state)
            IDLE: begin
                if (w_e_reload) begin
                    w_cdw_n = START;
                    w_cdb_n = START;
                end
                if (w_e_start) begin
                    w_state_n = RUN_W;
                    w_pre_n   = '0;
                    w_turn_n  = 1'b0;
                end
            end
            RUN_W: begin
                w_pre_n = w_pre_inc;
                if (w_tick) w_cdw_n = w_dec_w;
                if (w_tick && w_dec_w == 10'd0) begin
                    w_state_n = FLAG;
                    w_fw_n    = 1'b1;
                end else if (w_e_pw) begin
                    w_state_n = RUN_B;
                    w_turn_n  = 1'b1;
                    w_pre_n   = '0;
                end else if (w_e_pause) w_state_n = PAUSED;
            end
            RUN_B: begin
                w_pre_n = w_pre_inc;
                if (w_tick) w_cdb_n = w_dec_b;
                if (w_tick && w_dec_b == 10'd0) begin
                    w_state_n = FLAG;
                    w_fb_n    = 1'b1;
                end else if (w_e_pb) begin
                    w_state_n = RUN_W;
                    w_turn_n  = 1'b0;
                    w_pre_n   = '0;
                end else if (w_e_pause) w_state_n = PAUSED;
            end
            PAUSED: begin
                if (w_e_reload) begin
                    w_state_n = IDLE;
                    w_cdw_n   = START;
                    w_cdb_n   = START;
                    w_turn_n  = 1'b0;
                    w_pre_n   = '0;
                end else if (w_e_pause) w_state_n = r_turn ? RUN_B : RUN_W;
            end
            FLAG: begin
                if (w_e_reload) begin
                    w_state_n = IDLE;
                    w_cdw_n   = START;
                    w_cdb_n   = START;
                    w_turn_n  = 1'b0;
                    w_pre_n   = '0;
                    w_fw_n    = 1'b0;
                    w_fb_n    = 1'b0;
                end
            end
            default: w_state_n = IDLE;
        endcase
        w_run_n = (w_state_n == RUN_W) || (w_state_n == RUN_B);
    end

    // History regs load the live inputs during reset so release never creates an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pre      <= '0;
            r_cdw      <= START;
            r_cdb      <= START;
            r_turn     <= 1'b0;
            r_run      <= 1'b0;
            r_fw       <= 1'b0;
            r_fb       <= 1'b0;
            r_start_d  <= start;
            r_pw_d     <= press_w;
            r_pb_d     <= press_b;
            r_pause_d  <= pause;
            r_reload_d <= reload;
        end else begin
            r_state    <= w_state_n;
            r_pre      <= w_pre_n;
            r_cdw      <= w_cdw_n;
            r_cdb      <= w_cdb_n;
            r_turn     <= w_turn_n;
            r_run      <= w_run_n;
            r_fw       <= w_fw_n;
            r_fb       <= w_fb_n;
            r_start_d  <= start;
            r_pw_d     <= press_w;
            r_pb_d     <= press_b;
            r_pause_d  <= pause;
            r_reload_d <= reload;
        end
    end

    assign countdownW = r_cdw;
    assign countdownB = r_cdb;
    assign turn_b     = r_turn;
    assign running    = r_run;
    assign flagW      = r_fw;
    assign flagB      = r_fb;
endmodule

// File: tb/tb_chess_clock_controller.sv
// tb_chess_clock_controller: directed plus random stimulus against a seconds-based reference model.
module tb_chess_clock_controller;
    localparam int TPS = 4;
    localparam int START_S = 12;
    localparam int M_IDLE = 0, M_RW = 1, M_RB = 2, M_PAUSE = 3, M_FLAG = 4;

    logic clk = 1'b0, rst = 1'b1;
    logic start = 1'b0, press_w = 1'b0, press_b = 1'b0, pause = 1'b0, reload = 1'b0;
    logic [9:0] countdownW, countdownB;
    logic turn_b, running, flagW, flagB;

    int errors = 0, checks = 0;
    int ws, bs, ph, mst, mt, fw, fb;
    bit p_st, p_pw, p_pb, p_pa, p_rl;

    chess_clock_controller #(.TICKS_PER_SEC(TPS), .START_MIN(0), .START_TENS(1), .START_UNITS(2)) dut (
        .clk(clk), .rst(rst), .start(start), .press_w(press_w), .press_b(press_b), .pause(pause),
        .reload(reload), .countdownW(countdownW), .countdownB(countdownB), .turn_b(turn_b),
        .running(running), .flagW(flagW), .flagB(flagB)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] pk(input int s);
        return {3'(s / 60), 3'((s % 60) / 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mst = M_IDLE; ws = START_S; bs = START_S; ph = 0; mt = 0; fw = 0; fb = 0;
        p_st = start; p_pw = press_w; p_pb = press_b; p_pa = pause; p_rl = reload;
    endtask

    task automatic to_idle();
        mst = M_IDLE; ws = START_S; bs = START_S; mt = 0; ph = 0;
    endtask

    task automatic model_clock();
        bit est, epw, epb, epa, erl, tick;
        int act;
        est = start & ~p_st; epw = press_w & ~p_pw; epb = press_b & ~p_pb;
        epa = pause & ~p_pa; erl = reload & ~p_rl;
        p_st = start; p_pw = press_w; p_pb = press_b; p_pa = pause; p_rl = reload;
        case (mst)
            M_IDLE: begin
                if (erl) begin ws = START_S; bs = START_S; end
                if (est) begin mst = M_RW; ph = 0; mt = 0; end
            end
            M_RW, M_RB: begin
                tick = (ph == TPS - 1);
                ph = tick ? 0 : ph + 1;
                act = mt ? bs : ws;
                if (tick && act > 0) act--;
                if (mt) bs = act; else ws = act;
                if (tick && act == 0) begin
                    mst = M_FLAG;
                    if (mt) fb = 1; else fw = 1;
                end else if (mt ? epb : epw) begin
                    mt = !mt; ph = 0; mst = mt ? M_RB : M_RW;
                end else if (epa) mst = M_PAUSE;
            end
            M_PAUSE: begin
                if (erl) to_idle();
                else if (epa) mst = mt ? M_RB : M_RW;
            end
            default: if (erl) begin to_idle(); fw = 0; fb = 0; end
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".cdW"}, countdownW, pk(ws));
        chk({tag, ".cdB"}, countdownB, pk(bs));
        chk({tag, ".turn"}, {9'd0, turn_b}, 10'(mt));
        chk({tag, ".run"}, {9'd0, running}, 10'(mst == M_RW || mst == M_RB));
        chk({tag, ".flagW"}, {9'd0, flagW}, 10'(fw));
        chk({tag, ".flagB"}, {9'd0, flagB}, 10'(fb));
    endtask

    task automatic step(input bit s, input bit pw, input bit pb, input bit pa, input bit rl);
        start = s; press_w = pw; press_b = pb; pause = pa; reload = rl;
        @(posedge clk);
        #1;
        model_clock();
        check_all("step");
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_all("post_reset");

        step(1, 0, 0, 0, 0);
        chk("t1_running", {9'd0, running}, 10'd1);
        repeat (4) step(0, 0, 0, 0, 0);
        chk("t1_w011", countdownW, 10'h011);
        repeat (8) step(0, 0, 0, 0, 0);
        chk("t1_w009", countdownW, 10'h009);
        chk("t1_b012", countdownB, 10'h012);

        step(0, 1, 0, 0, 0);
        chk("t2_turnb", {9'd0, turn_b}, 10'd1);
        repeat (4) step(0, 1, 0, 0, 0);
        chk("t2_b011", countdownB, 10'h011);
        chk("t2_w009", countdownW, 10'h009);

        step(0, 0, 1, 0, 0);
        for (int k = 0; k < 200 && !(ws == 1 && ph == TPS - 1); k++) step(0, 0, 0, 0, 0);
        chk("t3_w001", countdownW, 10'h001);
        step(0, 1, 0, 0, 0);
        chk("t3_w000", countdownW, 10'h000);
        chk("t3_flagW", {9'd0, flagW}, 10'd1);
        chk("t3_run0", {9'd0, running}, 10'd0);
        chk("t3_turn0", {9'd0, turn_b}, 10'd0);

        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("t5_flag_hold", {9'd0, flagW}, 10'd1);
        step(0, 0, 0, 0, 1);
        chk("t5_w012", countdownW, 10'h012);
        chk("t5_b012", countdownB, 10'h012);
        chk("t5_flags", {8'd0, flagW, flagB}, 10'd0);

        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        repeat (20) step(0, 0, 0, 0, 0);
        chk("t4_frozen", countdownW, 10'h012);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("t4_notyet", countdownW, 10'h012);
        step(0, 0, 0, 0, 0);
        chk("t4_tick", countdownW, 10'h011);

        step(0, 0, 0, 0, 1);
        chk("t5_reload_run", countdownW, 10'h011);
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0, 0);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all("t6_async");
        chk("t6_b012", countdownB, 10'h012);
        #1 rst = 1'b0;

        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
